// File: rtl/fp16_align_stage.sv
// fp16_align_stage
// Exponent-alignment front end for a half-precision adder. Accepts an
// operand pair, orders it so the larger magnitude sits on the A side, and
// right-shifts the smaller significand one bit per cycle until both share
// the larger exponent. The aligned pair is held until downstream takes it.
//
// The effective-subtract flag is named checker_o because "checker" is a
// reserved word in SystemVerilog-2012.

module fp16_align_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] a_mant,
    output logic [10:0] Bshifted,
    output logic [10:0] Bshiftedcomp,
    output logic        checker_o,
    output logic [4:0]  exp_out,
    output logic        sign_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic [10:0] aMant_q;
    logic [10:0] bShift_q;
    logic [4:0]  exp_q;
    logic        sign_q;
    logic        checker_q;
    logic        outValid_q;
    logic        inReady_q;

    // Unpacked operand fields
    logic [4:0]  expA;
    logic [4:0]  expB;
    logic [4:0]  effExpA;
    logic [4:0]  effExpB;
    logic [10:0] sigA;
    logic [10:0] sigB;
    logic        aSmaller;
    logic [4:0]  expDiff;

    // Values loaded into the registers when a pair is accepted
    logic [10:0] aMant_d;
    logic [10:0] bShift_d;
    logic [4:0]  exp_d;
    logic        sign_d;
    logic        checker_d;
    logic [3:0]  count_d;

    // Unpack both operands, pick the larger magnitude and derive the shift count
    always_comb begin
        expA    = a_in[14:10];
        expB    = b_in[14:10];
        effExpA = (expA == 5'd0) ? 5'd1 : expA;
        effExpB = (expB == 5'd0) ? 5'd1 : expB;
        sigA    = {(expA != 5'd0), a_in[9:0]};
        sigB    = {(expB != 5'd0), b_in[9:0]};

        aSmaller = (effExpA < effExpB) ||
                   ((effExpA == effExpB) && (sigA < sigB));

        if (aSmaller) begin
            aMant_d  = sigB;
            bShift_d = sigA;
            exp_d    = effExpB;
            sign_d   = b_in[15];
            expDiff  = effExpB - effExpA;
        end else begin
            aMant_d  = sigA;
            bShift_d = sigB;
            exp_d    = effExpA;
            sign_d   = a_in[15];
            expDiff  = effExpA - effExpB;
        end

        checker_d = a_in[15] ^ b_in[15];
        count_d   = (expDiff > 5'd11) ? 4'd11 : expDiff[3:0];
    end

    // Handshake FSM and alignment datapath; shifts one bit per ALIGN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            aMant_q    <= 11'd0;
            bShift_q   <= 11'd0;
            exp_q      <= 5'd0;
            sign_q     <= 1'b0;
            checker_q  <= 1'b0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && inReady_q) begin
                        aMant_q   <= aMant_d;
                        bShift_q  <= bShift_d;
                        exp_q     <= exp_d;
                        sign_q    <= sign_d;
                        checker_q <= checker_d;
                        count_q   <= count_d;
                        inReady_q <= 1'b0;
                        state_q   <= ALIGN;
                    end else begin
                        inReady_q <= 1'b1;
                    end
                end
                ALIGN: begin
                    if (count_q != 4'd0) begin
                        bShift_q <= bShift_q >> 1;
                        count_q  <= count_q - 4'd1;
                    end else begin
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = inReady_q;
    assign out_valid    = outValid_q;
    assign a_mant       = aMant_q;
    assign Bshifted     = bShift_q;
    assign Bshiftedcomp = 11'd0 - bShift_q;
    assign checker_o    = checker_q;
    assign exp_out      = exp_q;
    assign sign_out     = sign_q;

endmodule

// File: tb/tb_fp16_align_stage.sv
// Testbench for fp16_align_stage: directed vector table, hand-written
// back-pressure and reset-abort sequences, and random pairs checked
// against an arithmetic reference model.

module tb_fp16_align_stage;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [10:0] amant;
        logic [10:0] bsh;
        logic [10:0] comp;
        logic        chk;
        logic [4:0]  expo;
        logic        sgn;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] a_mant;
    logic [10:0] Bshifted;
    logic [10:0] Bshiftedcomp;
    logic        checkerOut;
    logic [4:0]  exp_out;
    logic        sign_out;

    int checks = 0;
    int errors = 0;

    fp16_align_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .a_mant       (a_mant),
        .Bshifted     (Bshifted),
        .Bshiftedcomp (Bshiftedcomp),
        .checker_o    (checkerOut),
        .exp_out      (exp_out),
        .sign_out     (sign_out)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: order by numeric magnitude, shift by integer division
    function automatic vec_t refModel(input logic [15:0] a, input logic [15:0] b);
        vec_t   v;
        int     ea, eb, sa, sb, eL, eS, sL, sS, d, sh;
        longint ma, mb;
        logic   sL_sign;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        sa = (ea != 0) ? 1024 + int'(a[9:0]) : int'(a[9:0]);
        sb = (eb != 0) ? 1024 + int'(b[9:0]) : int'(b[9:0]);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        ma = longint'(sa) * (longint'(1) << ea);
        mb = longint'(sb) * (longint'(1) << eb);
        if (ma < mb) begin
            eL = eb; sL = sb; eS = ea; sS = sa; sL_sign = b[15];
        end else begin
            eL = ea; sL = sa; eS = eb; sS = sb; sL_sign = a[15];
        end
        d = eL - eS;
        if (d > 11) d = 11;
        sh = sS / (1 << d);
        v.a     = a;
        v.b     = b;
        v.amant = 11'(sL);
        v.bsh   = 11'(sh);
        v.comp  = 11'((2048 - sh) % 2048);
        v.chk   = a[15] ^ b[15];
        v.expo  = 5'(eL);
        v.sgn   = sL_sign;
        v.lat   = d + 1;
        return v;
    endfunction

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        checkValue({name, " a_mant"},       int'(a_mant),       int'(v.amant));
        checkValue({name, " Bshifted"},     int'(Bshifted),     int'(v.bsh));
        checkValue({name, " Bshiftedcomp"}, int'(Bshiftedcomp), int'(v.comp));
        checkValue({name, " checker"},      int'(checkerOut),   int'(v.chk));
        checkValue({name, " exp_out"},      int'(exp_out),      int'(v.expo));
        checkValue({name, " sign_out"},     int'(sign_out),     int'(v.sgn));
    endtask

    task automatic checkAllZero(input string name);
        checkValue({name, " in_ready"},     int'(in_ready),     0);
        checkValue({name, " out_valid"},    int'(out_valid),    0);
        checkValue({name, " a_mant"},       int'(a_mant),       0);
        checkValue({name, " Bshifted"},     int'(Bshifted),     0);
        checkValue({name, " Bshiftedcomp"}, int'(Bshiftedcomp), 0);
        checkValue({name, " checker"},      int'(checkerOut),   0);
        checkValue({name, " exp_out"},      int'(exp_out),      0);
        checkValue({name, " sign_out"},     int'(sign_out),     0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents the pair for one edge, then measures latency
    task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b,
                                 output int lat);
        int waitCycles;
        waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s in_ready timeout: got 0, expected 1", name);
        end
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkValue({name, " in_ready after accept"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic runPair(input string name, input vec_t v);
        int lat;
        applyStimulus(name, v.a, v.b, lat);
        checkValue({name, " latency"}, lat, v.lat);
        checkOutput(name, v);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkValue({name, " out_valid drop"}, int'(out_valid), 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   lat;
        int   sawValid;

        vecs[0] = '{16'h3C00, 16'h3800, 11'h400, 11'h200, 11'h600, 1'b0, 5'd15, 1'b0, 2};
        vecs[1] = '{16'h3800, 16'hBC00, 11'h400, 11'h200, 11'h600, 1'b1, 5'd15, 1'b1, 2};
        vecs[2] = '{16'h7800, 16'h3C00, 11'h400, 11'h000, 11'h000, 1'b0, 5'd30, 1'b0, 12};
        vecs[3] = '{16'h0001, 16'h0400, 11'h400, 11'h001, 11'h7FF, 1'b0, 5'd1,  1'b0, 1};
        vecs[4] = '{16'h3C00, 16'hBC00, 11'h400, 11'h400, 11'h400, 1'b1, 5'd15, 1'b0, 1};
        vecs[5] = '{16'h7C00, 16'h7A00, 11'h400, 11'h300, 11'h500, 1'b0, 5'd31, 1'b0, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 16'h0;
        b_in      = 16'h0;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();
        checkValue("in_ready after reset", int'(in_ready), 1);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            runPair($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-pressure: hold out_ready low in DONE, offer a new pair meanwhile
        v = refModel(16'h3C00, 16'h3800);
        applyStimulus("stall", v.a, v.b, lat);
        checkValue("stall latency", lat, v.lat);
        a_in     = 16'h5555;
        b_in     = 16'h1234;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checkValue("stall out_valid", int'(out_valid), 1);
            checkValue("stall in_ready", int'(in_ready), 0);
            checkOutput("stall", v);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkValue("stall release out_valid", int'(out_valid), 0);
        checkValue("stall release in_ready", int'(in_ready), 1);
        checkOutput("stall held", v);
        repeat (3) tick();
        checkValue("stall no extra accept", int'(out_valid), 0);

        // Reset mid-ALIGN aborts the pair
        a_in     = 16'h7800;
        b_in     = 16'h3C00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        checkAllZero("abort");
        rst_n = 1'b1;
        sawValid = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) sawValid = 1;
        end
        checkValue("abort no out_valid", sawValid, 0);
        checkValue("abort in_ready", int'(in_ready), 1);
        runPair("post-abort", vecs[0]);

        // Random pairs against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) rb[14:10] = ra[14:10] + 5'($urandom_range(0, 3));
            runPair($sformatf("rand%0d", i), refModel(ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fp16_align_stage.md
FP16_ALIGN_STAGE -- requirements
Module: fp16_align_stage

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: rst_n, input, 1, reset, synchronous, active-low.
REQ-003 The block SHALL have these ports: in_valid, input, 1, operand pair present.
REQ-004 The block SHALL have these ports: in_ready, output, 1, block can accept a pair.
REQ-005 The block SHALL have these ports: a_in, input, 16, IEEE half-precision operand A (sign[15], exp[14:10], frac[9:0]).
REQ-006 The block SHALL have these ports: b_in, input, 16, half-precision operand B.
REQ-007 The block SHALL have these ports: out_valid, output, 1, aligned result present.
REQ-008 The block SHALL have these ports: out_ready, input, 1, downstream consumes the result.
REQ-009 The block SHALL have these ports: a_mant, output, 11, larger-magnitude significand with hidden bit.
REQ-010 The block SHALL have these ports: Bshifted, output, 11, smaller significand right-aligned to exp_out.
REQ-011 The block SHALL have these ports: Bshiftedcomp, output, 11, two's complement of Bshifted, modulo 2^11.
REQ-012 The block SHALL have these ports: checker, output, 1, sign_a XOR sign_b (1 = effective subtract).
REQ-013 The block SHALL have these ports: exp_out, output, 5, exponent of the larger operand.
REQ-014 The block SHALL have these ports: sign_out, output, 1, sign of the larger operand.

Function
REQ-015 The block SHALL unpack each operand as follows: exp != 0 -> significand {1,frac}, effective exponent = exp; exp == 0 -> significand {0,frac}, effective exponent = 1.
REQ-016 The block SHALL treat exp == 31 as an ordinary exponent; it SHALL NOT perform Inf/NaN handling.
REQ-017 The block SHALL swap operands when A is smaller, so that the larger operand appears on the A side. A is smaller when eff_exp_a < eff_exp_b, or when the exponents are equal and sig_a < sig_b.
REQ-018 The block SHALL compute shift count d = min(eff_exp_large - eff_exp_small, 11).
REQ-019 The FSM SHALL have three states: IDLE, ALIGN and DONE; the reset state SHALL be IDLE.
REQ-020 In IDLE, the block SHALL assert in_ready = 1.
REQ-021 In IDLE, when in_valid = 1, the block SHALL at the edge load the swapped operands, load count = d, and move to ALIGN.
REQ-022 In ALIGN with count > 0, each edge SHALL shift the small significand right by 1 with zero fill and decrement count.
REQ-023 In ALIGN with count == 0, the next edge SHALL move to DONE.
REQ-024 Shifted-out bits SHALL be discarded; no guard or sticky bits are produced.
REQ-025 Latency: out_valid SHALL rise exactly d+1 cycles after the accepting edge.
REQ-026 In DONE, the block SHALL assert out_valid = 1 and hold all outputs stable until out_ready = 1.
REQ-027 In DONE, an edge with out_ready = 1 SHALL move the FSM to IDLE.
REQ-028 in_ready SHALL be 0 in ALIGN and DONE; in_valid SHALL be ignored in those states.
REQ-029 The minimum accept-to-accept interval SHALL be d+3 cycles.
REQ-030 Bshiftedcomp SHALL equal (2^11 - Bshifted) mod 2^11; Bshifted = 0 SHALL give Bshiftedcomp = 0.
REQ-031 checker and sign_out SHALL be captured at accept and held until the next accept.
REQ-032 Equal magnitudes SHALL NOT trigger a swap; A is retained, and sign_out = sign_a.

Reset
REQ-033 While rst_n = 0 at an edge, the block SHALL force state = IDLE, count = 0, and all data outputs = 0.
REQ-034 While rst_n = 0 at an edge, the block SHALL force out_valid = 0 and in_ready = 0.
REQ-035 The block SHALL assert in_ready = 1 from the first edge with rst_n = 1.
REQ-036 Reset asserted during ALIGN or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted pair.

Verification
REQ-037 The bench SHALL check: A=0x3C00, B=0x3800 -> a_mant=0x400, Bshifted=0x200, Bshiftedcomp=0x600, checker=0, exp_out=15, sign_out=0, out_valid 2 cycles after accept.
REQ-038 The bench SHALL check: A=0x3800, B=0xBC00 -> swap; a_mant=0x400, Bshifted=0x200, checker=1, sign_out=1, exp_out=15.
REQ-039 The bench SHALL check: A=0x7800, B=0x3C00 -> d clamped to 11; Bshifted=0x000, Bshiftedcomp=0x000, exp_out=30, latency 12 cycles.
REQ-040 The bench SHALL check: A=0x0001, B=0x0400 (subnormal) -> swap; a_mant=0x400, Bshifted=0x001, Bshiftedcomp=0x7FF, exp_out=1, latency 1.
REQ-041 The bench SHALL check: out_ready held low 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; a new in_valid in that window is not accepted.
REQ-042 The bench SHALL check: rst_n = 0 for one edge mid-ALIGN on the 0x7800/0x3C00 pair -> IDLE, all outputs 0, no out_valid; a pair applied afterwards completes normally.
